// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per cycle, LSB slice first, over WIDTH/DIGIT cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A - B via ~B and forced carry-in).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             c_out
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder: DIGIT must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [WIDTH-1:0] b_in;
    logic             c_init;
    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] sum_full;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_in   = sub ? ~B : B;
    assign c_init = sub | c_in;
`else
    assign b_in   = B;
    assign c_init = c_in;
`endif

    assign slice_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // New slice enters at the top; after N cycles the register holds the whole sum in order.
    assign sum_full  = (sum_sh >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last      = (cnt == CW'(N - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            S      <= '0;
            c_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= b_in;
                        carry  <= c_init;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    carry  <= slice_sum[DIGIT];
                    sum_sh <= sum_full;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        S     <= sum_full;
                        c_out <= slice_sum[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: two instances (DIGIT=1 and DIGIT=4) share stimulus and are
// checked each cycle against a cycle-count/arithmetic model, plus literal expectations.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A, B;
    logic       c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy1, done1, co1;
    logic [7:0] s1;
    logic       busy4, done4, co4;
    logic [7:0] s4;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy1), .done(done1), .S(s1), .c_out(co1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy4), .done(done4), .S(s4), .c_out(co4)
    );

    // Model: an accepted op keeps the block busy for N+1 cycles, done on the last one,
    // and the result is plain (WIDTH+1)-bit arithmetic.
    int         rem [2];
    logic [8:0] res [2];
    logic [7:0] exp_s [2];
    logic       exp_c [2];

    function automatic int n_of(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b,
                                             input logic c, input logic sb);
        logic [7:0] nb;
        nb = ~b;
        if (sb) return {1'b0, a} + {1'b0, nb} + 9'd1;
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rem[i]   = 0;
                exp_s[i] = 8'h00;
                exp_c[i] = 1'b0;
            end else if (rem[i] == 0) begin
                if (start) begin
                    rem[i] = n_of(i) + 1;
`ifdef SERIAL_ADDER_SUB_EN
                    res[i] = model_sum(A, B, c_in, sub);
`else
                    res[i] = model_sum(A, B, c_in, 1'b0);
`endif
                end
            end else begin
                rem[i] = rem[i] - 1;
                if (rem[i] == 1) {exp_c[i], exp_s[i]} = res[i];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Called at a negedge with both instances idle; returns what each showed while done was high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic sb, input bit inject,
                          output logic [7:0] r1, output logic rc1, output int e1,
                          output int busy_n, output int pulses,
                          output logic [7:0] r4, output logic rc4, output int e4);
        int n;
        A = a; B = b; c_in = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sb;
`endif
        start = 1'b1;
        e1 = 0; e4 = 0; busy_n = 0; pulses = 0;
        r1 = 8'h00; rc1 = 1'b0; r4 = 8'h00; rc4 = 1'b0;
        n = 0;
        while ((e1 == 0 || e4 == 0) && n < 40) begin
            @(posedge clk); n++; #1;
            if (busy1) busy_n++;
            if (done1) pulses++;
            if (done1 && e1 == 0) begin e1 = n; r1 = s1; rc1 = co1; end
            if (done4 && e4 == 0) begin e4 = n; r4 = s4; rc4 = co4; end
            if (n == 1) begin start = 1'b0; A = ~a; B = ~b; c_in = ~c; end
            if (inject && n == 3) begin start = 1'b1; A = 8'h11; end
            if (inject && n == 4) start = 1'b0;
        end
        if (e1 == 0 || e4 == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL op_timeout: got no done within %0d edges, expected done", n);
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        @(negedge clk);
    endtask

    logic [7:0] r1, r4;
    logic       rc1, rc4;
    int         e1, e4, busy_n, pulses;

    typedef struct { logic [7:0] a; logic [7:0] b; logic c; logic [7:0] s; logic co; } vec_t;
    vec_t tbl [3] = '{
        '{a: 8'h80, b: 8'h80, c: 1'b1, s: 8'h01, co: 1'b1},
        '{a: 8'h7F, b: 8'h00, c: 1'b1, s: 8'h80, co: 1'b0},
        '{a: 8'h12, b: 8'h34, c: 1'b0, s: 8'h46, co: 1'b0}
    };

    initial begin
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        fork
            forever begin
                @(negedge clk);
                chk("busy_d1",  {31'd0, busy1}, {31'd0, rem[0] != 0});
                chk("done_d1",  {31'd0, done1}, {31'd0, rem[0] == 1});
                chk("S_d1",     {24'd0, s1},    {24'd0, exp_s[0]});
                chk("cout_d1",  {31'd0, co1},   {31'd0, exp_c[0]});
                chk("busy_d4",  {31'd0, busy4}, {31'd0, rem[1] != 0});
                chk("done_d4",  {31'd0, done4}, {31'd0, rem[1] == 1});
                chk("S_d4",     {24'd0, s4},    {24'd0, exp_s[1]});
                chk("cout_d4",  {31'd0, co4},   {31'd0, exp_c[1]});
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy1}, 32'd0);
        chk("reset_S",    {24'd0, s1},    32'd0);
        rst = 1'b0;

        // first start right after reset release; zero operands
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("zero_S", {24'd0, r1}, 32'h00);
        chk("zero_cout", {31'd0, rc1}, 32'd0);
        chk("zero_latency_d1", e1, 32'd9);
        chk("zero_busy_cycles", busy_n, 32'd9);
        chk("zero_latency_d4", e4, 32'd3);
        chk("zero_pulses", pulses, 32'd1);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("ff01_S", {24'd0, r1}, 32'h00);
        chk("ff01_cout", {31'd0, rc1}, 32'd1);
        chk("ff01_S_d4", {24'd0, r4}, 32'h00);
        chk("ff01_cout_d4", {31'd0, rc4}, 32'd1);

        run_op(8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("5aa5_S", {24'd0, r1}, 32'h00);
        chk("5aa5_cout", {31'd0, rc1}, 32'd1);

        // restart attempt mid-RUN must be ignored
        run_op(8'h22, 8'h33, 1'b0, 1'b0, 1'b1, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("ignore_S", {24'd0, r1}, 32'h55);
        chk("ignore_cout", {31'd0, rc1}, 32'd0);
        chk("ignore_pulses", pulses, 32'd1);

        // reset between edges, 4 cycles into RUN
        A = 8'h44; B = 8'h11; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_S", {24'd0, s1}, 32'd0);
        chk("abort_S_d4", {24'd0, s4}, 32'd0);
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        chk("abort_no_done", pulses, 32'd0);
        @(negedge clk);

        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("after_abort_S", {24'd0, r1}, 32'h07);

        run_op(8'h9C, 8'h77, 1'b0, 1'b0, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("9c77_S_d4", {24'd0, r4}, 32'h13);
        chk("9c77_cout_d4", {31'd0, rc4}, 32'd1);
        chk("9c77_latency_d4", e4, 32'd3);
        chk("9c77_S_d1", {24'd0, r1}, 32'h13);

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
            chk("tbl_S", {24'd0, r1}, {24'd0, tbl[i].s});
            chk("tbl_cout", {31'd0, rc1}, {31'd0, tbl[i].co});
            chk("tbl_S_d4", {24'd0, r4}, {24'd0, tbl[i].s});
        end

        // start held high: one op per N+2 cycles
        A = 8'h21; B = 8'h43; c_in = 1'b1; start = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        start = 1'b0;
        chk("b2b_pulses", pulses, 32'd3);
        chk("b2b_S", {24'd0, s1}, 32'h65);
        repeat (12) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("sub_1001_S", {24'd0, r1}, 32'h0F);
        chk("sub_1001_cout", {31'd0, rc1}, 32'd1);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("sub_0102_S", {24'd0, r1}, 32'hFF);
        chk("sub_0102_cout", {31'd0, rc1}, 32'd0);
        run_op(8'h10, 8'h01, 1'b1, 1'b0, 1'b0, r1, rc1, e1, busy_n, pulses, r4, rc4, e4);
        chk("sub_off_S", {24'd0, r1}, 32'h12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
